// File: rtl/uart_packet_parser.sv
`default_nettype none
// ============================================================================
// Module      : uart_packet_parser
// Description : Parses [opcode, reserved, len_lo, len_hi, payload] packets
//               from a UART RX byte stream. ECHO payload is passed through
//               combinationally. ALU payload is assembled into little-endian
//               operands of OP_BYTES bytes each. Bad opcodes and lengths are
//               flagged, bad packets are drained, and the parser resyncs.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_packet_parser #(
  parameter int OP_BYTES = 4,
  parameter int LEN_W    = 16,
  parameter int MAX_OPS  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  output logic [7:0]            echo_data_o,
  output logic                  echo_valid_o,
  input  logic                  echo_ready_i,
  output logic [8*OP_BYTES-1:0] opnd_data_o,
  output logic                  opnd_valid_o,
  output logic                  opnd_last_o,
  output logic [7:0]            opnd_opcode_o,
  input  logic                  opnd_ready_i,
  output logic                  err_o,
  output logic [1:0]            err_code_o,
  output logic                  busy_o
);

  localparam int c_DW    = 8 * OP_BYTES;
  localparam int c_CNT_W = (OP_BYTES > 1) ? $clog2(OP_BYTES) : 1;

  localparam logic [7:0] c_OPC_ECHO = 8'h01;
  localparam logic [7:0] c_OPC_ADD  = 8'h02;
  localparam logic [7:0] c_OPC_MUL  = 8'h03;
  localparam logic [7:0] c_OPC_DIV  = 8'h04;

  localparam logic [1:0] c_ERR_BAD_OP    = 2'd1;
  localparam logic [1:0] c_ERR_LEN_SHORT = 2'd2;
  localparam logic [1:0] c_ERR_BAD_LEN   = 2'd3;

  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(OP_BYTES - 1);
  localparam logic [31:0]        c_DIV_PAY  = 32'(2 * OP_BYTES);
  localparam logic [31:0]        c_MAX_PAY  = 32'(MAX_OPS * OP_BYTES);
  localparam logic [31:0]        c_OPB32    = 32'(OP_BYTES);

  typedef enum logic [2:0] {
    S_OPCODE   = 3'd0,
    S_RSVD     = 3'd1,
    S_LEN_LO   = 3'd2,
    S_LEN_HI   = 3'd3,
    S_ECHO     = 3'd4,
    S_OPND     = 3'd5,
    S_OPND_OUT = 3'd6,
    S_DRAIN    = 3'd7
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [7:0]           r_opcode;
  logic [7:0]           r_len_lo;
  logic [LEN_W-1:0]     r_rem;
  logic [c_CNT_W-1:0]   r_byte_cnt;
  logic [c_DW-1:0]      r_shift;
  logic                 r_last;
  logic                 r_err;
  logic [1:0]           r_err_code;

  logic                 w_rx_ready;
  logic                 w_echo_valid;
  logic                 w_opnd_valid;
  logic                 w_err_set;
  logic [1:0]           w_err_code_nxt;
  logic                 w_load_len;
  logic                 w_dec_rem;
  logic                 w_shift_en;

  logic [15:0]          w_len_full;
  logic [LEN_W-1:0]     w_len;
  logic [31:0]          w_len32;
  logic [31:0]          w_pay32;
  logic                 w_len_short;
  logic                 w_len_empty;
  logic                 w_is_div;
  logic                 w_bad_len;
  logic                 w_opc_ok;
  logic [LEN_W-1:0]     w_rem_dec;
  logic [c_DW-1:0]      w_shift_nxt;

  // Length decode from the byte currently presented in LEN_HI
  assign w_len_full  = {rx_data_i, r_len_lo};
  assign w_len       = LEN_W'(w_len_full);
  assign w_len32     = 32'(w_len);
  assign w_pay32     = w_len32 - 32'd4;
  assign w_len_short = (w_len32 < 32'd4);
  assign w_len_empty = (w_len32 == 32'd4);
  assign w_is_div    = (r_opcode == c_OPC_DIV);
  // Any non-ECHO opcode latched here is an ALU opcode
  assign w_bad_len   = (r_opcode != c_OPC_ECHO) &&
                       (((w_pay32 % c_OPB32) != 32'd0) ||
                        (w_is_div && (w_pay32 != c_DIV_PAY)) ||
                        (!w_is_div && (w_pay32 > c_MAX_PAY)));

  assign w_opc_ok  = (rx_data_i == c_OPC_ECHO) || (rx_data_i == c_OPC_ADD) ||
                     (rx_data_i == c_OPC_MUL)  || (rx_data_i == c_OPC_DIV);
  assign w_rem_dec = (r_rem != '0) ? (r_rem - LEN_W'(1)) : r_rem;

  // New byte enters at the top so the first byte lands in [7:0]
  generate
    if (OP_BYTES == 1) begin : g_shift_single
      assign w_shift_nxt = rx_data_i;
    end else begin : g_shift_multi
      assign w_shift_nxt = {rx_data_i, r_shift[c_DW-1:8]};
    end
  endgenerate

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_OPCODE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and handshake decode
  always_comb begin
    w_state_nxt    = r_state;
    w_rx_ready     = 1'b0;
    w_echo_valid   = 1'b0;
    w_opnd_valid   = 1'b0;
    w_err_set      = 1'b0;
    w_err_code_nxt = r_err_code;
    w_load_len     = 1'b0;
    w_dec_rem      = 1'b0;
    w_shift_en     = 1'b0;
    case (r_state)
      S_OPCODE: begin
        w_rx_ready = 1'b1;
        if (rx_valid_i) begin
          if (w_opc_ok) begin
            w_state_nxt = S_RSVD;
          end else begin
            w_err_set      = 1'b1;
            w_err_code_nxt = c_ERR_BAD_OP;
          end
        end
      end
      S_RSVD: begin
        w_rx_ready = 1'b1;
        if (rx_valid_i) w_state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        w_rx_ready = 1'b1;
        if (rx_valid_i) w_state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        w_rx_ready = 1'b1;
        if (rx_valid_i) begin
          w_load_len = 1'b1;
          if (w_len_short) begin
            w_err_set      = 1'b1;
            w_err_code_nxt = c_ERR_LEN_SHORT;
            w_state_nxt    = S_OPCODE;
          end else if (w_len_empty) begin
            w_state_nxt = S_OPCODE;
          end else if (w_bad_len) begin
            w_err_set      = 1'b1;
            w_err_code_nxt = c_ERR_BAD_LEN;
            w_state_nxt    = S_DRAIN;
          end else if (r_opcode == c_OPC_ECHO) begin
            w_state_nxt = S_ECHO;
          end else begin
            w_state_nxt = S_OPND;
          end
        end
      end
      S_ECHO: begin
        w_rx_ready   = echo_ready_i;
        w_echo_valid = rx_valid_i;
        if (rx_valid_i && echo_ready_i) begin
          w_dec_rem = 1'b1;
          if (r_rem <= LEN_W'(1)) w_state_nxt = S_OPCODE;
        end
      end
      S_OPND: begin
        w_rx_ready = 1'b1;
        if (rx_valid_i) begin
          w_dec_rem  = 1'b1;
          w_shift_en = 1'b1;
          if (r_byte_cnt == c_CNT_LAST) w_state_nxt = S_OPND_OUT;
        end
      end
      S_OPND_OUT: begin
        w_opnd_valid = 1'b1;
        if (opnd_ready_i) w_state_nxt = (r_rem != '0) ? S_OPND : S_OPCODE;
      end
      S_DRAIN: begin
        w_rx_ready = 1'b1;
        if (rx_valid_i) begin
          w_dec_rem = 1'b1;
          if (r_rem <= LEN_W'(1)) w_state_nxt = S_OPCODE;
        end
      end
      default: w_state_nxt = S_OPCODE;
    endcase
  end

  // Header capture: opcode and low length byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opcode <= 8'h00;
      r_len_lo <= 8'h00;
    end else begin
      if ((r_state == S_OPCODE) && rx_valid_i && w_opc_ok) r_opcode <= rx_data_i;
      if ((r_state == S_LEN_LO) && rx_valid_i)             r_len_lo <= rx_data_i;
    end
  end

  // Remaining-payload down-counter; saturates at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem <= '0;
    end else if (w_load_len) begin
      r_rem <= w_len_short ? '0 : (w_len - LEN_W'(4));
    end else if (w_dec_rem) begin
      r_rem <= w_rem_dec;
    end
  end

  // Operand assembly: byte position counter, shift register, last flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_cnt <= '0;
      r_shift    <= '0;
      r_last     <= 1'b0;
    end else if (w_load_len) begin
      r_byte_cnt <= '0;
    end else if (w_shift_en) begin
      r_shift <= w_shift_nxt;
      if (r_byte_cnt == c_CNT_LAST) begin
        r_byte_cnt <= '0;
        r_last     <= (w_rem_dec == '0);
      end else begin
        r_byte_cnt <= r_byte_cnt + c_CNT_W'(1);
      end
    end
  end

  // Registered error pulse; the code is held until the next error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err      <= 1'b0;
      r_err_code <= 2'd0;
    end else begin
      r_err <= w_err_set;
      if (w_err_set) r_err_code <= w_err_code_nxt;
    end
  end

  // Ready is held low while reset is asserted so every output reads zero
  assign rx_ready_o    = w_rx_ready & ~rst;
  assign echo_valid_o  = w_echo_valid;
  assign echo_data_o   = (r_state == S_ECHO) ? rx_data_i : 8'h00;
  assign opnd_valid_o  = w_opnd_valid;
  assign opnd_data_o   = r_shift;
  assign opnd_last_o   = w_opnd_valid & r_last;
  assign opnd_opcode_o = r_opcode;
  assign err_o         = r_err;
  assign err_code_o    = r_err_code;
  assign busy_o        = (r_state != S_OPCODE);

endmodule
`default_nettype wire

// File: tb/tb_uart_packet_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_packet_parser
// Description : Self-checking bench for uart_packet_parser. Packets are built
//               from (opcode, length, payload) and the expected echo bytes,
//               operands and error codes are derived from the packet rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_packet_parser;

  localparam int OPB     = 4;
  localparam int LEN_W   = 16;
  localparam int MAX_OPS = 8;

  localparam logic [7:0] OP_ECHO = 8'h01;
  localparam logic [7:0] OP_ADD  = 8'h02;
  localparam logic [7:0] OP_MUL  = 8'h03;
  localparam logic [7:0] OP_DIV  = 8'h04;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data_i = 8'h00;
  logic              rx_valid_i = 1'b0;
  logic              rx_ready_o;
  logic [7:0]        echo_data_o;
  logic              echo_valid_o;
  logic              echo_ready_i = 1'b0;
  logic [8*OPB-1:0]  opnd_data_o;
  logic              opnd_valid_o;
  logic              opnd_last_o;
  logic [7:0]        opnd_opcode_o;
  logic              opnd_ready_i = 1'b0;
  logic              err_o;
  logic [1:0]        err_code_o;
  logic              busy_o;

  uart_packet_parser #(.OP_BYTES(OPB), .LEN_W(LEN_W), .MAX_OPS(MAX_OPS)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data_i    (rx_data_i),
    .rx_valid_i   (rx_valid_i),
    .rx_ready_o   (rx_ready_o),
    .echo_data_o  (echo_data_o),
    .echo_valid_o (echo_valid_o),
    .echo_ready_i (echo_ready_i),
    .opnd_data_o  (opnd_data_o),
    .opnd_valid_o (opnd_valid_o),
    .opnd_last_o  (opnd_last_o),
    .opnd_opcode_o(opnd_opcode_o),
    .opnd_ready_i (opnd_ready_i),
    .err_o        (err_o),
    .err_code_o   (err_code_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit hold_opnd = 1'b0;

  logic [7:0]  got_echo[$];
  logic [63:0] got_opnd[$];
  logic        got_last[$];
  logic [7:0]  got_opc[$];
  logic [1:0]  got_err[$];

  logic [7:0]  exp_echo[$];
  logic [63:0] exp_opnd[$];
  logic        exp_last[$];
  logic [7:0]  exp_opc[$];
  logic [1:0]  exp_err[$];

  logic [7:0]  next_pl[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Randomised downstream readiness, re-drawn every cycle
  initial begin
    forever begin
      @(posedge clk);
      #1;
      echo_ready_i = ($urandom_range(0, 3) != 0);
      opnd_ready_i = hold_opnd ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Collect completed handshakes and error pulses mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (echo_valid_o && echo_ready_i) got_echo.push_back(echo_data_o);
      if (opnd_valid_o && opnd_ready_i) begin
        got_opnd.push_back(64'(opnd_data_o));
        got_last.push_back(opnd_last_o);
        got_opc.push_back(opnd_opcode_o);
      end
      if (err_o) got_err.push_back(err_code_o);
    end
  end

  // Present one byte and hold it until accepted; caller sits just after a rising edge
  task automatic send_byte(input logic [7:0] b);
    int t;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!rx_ready_o && t < 500);
    if (!rx_ready_o) check_eq("rx_accept_timeout", 64'(rx_ready_o), 64'd1);
    @(posedge clk);
    #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((busy_o || opnd_valid_o) && t < 2000);
    if (busy_o) check_eq("idle_timeout", 64'(busy_o), 64'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_queues();
    got_echo.delete(); got_opnd.delete(); got_last.delete(); got_opc.delete(); got_err.delete();
    exp_echo.delete(); exp_opnd.delete(); exp_last.delete(); exp_opc.delete(); exp_err.delete();
  endtask

  task automatic compare_and_clear();
    check_eq("err_count", 64'(got_err.size()), 64'(exp_err.size()));
    for (int i = 0; i < got_err.size() && i < exp_err.size(); i++)
      check_eq("err_code", 64'(got_err[i]), 64'(exp_err[i]));
    check_eq("echo_count", 64'(got_echo.size()), 64'(exp_echo.size()));
    for (int i = 0; i < got_echo.size() && i < exp_echo.size(); i++)
      check_eq("echo_byte", 64'(got_echo[i]), 64'(exp_echo[i]));
    check_eq("opnd_count", 64'(got_opnd.size()), 64'(exp_opnd.size()));
    for (int i = 0; i < got_opnd.size() && i < exp_opnd.size(); i++) begin
      check_eq("opnd_data", got_opnd[i], exp_opnd[i]);
      check_eq("opnd_last", 64'(got_last[i]), 64'(exp_last[i]));
      check_eq("opnd_opcode", 64'(got_opc[i]), 64'(exp_opc[i]));
    end
    clear_queues();
  endtask

  // Build the expectation from the packet rules, then drive the packet
  task automatic run_packet(input logic [7:0] opc, input int len);
    logic [7:0]  pl[$];
    logic [63:0] v;
    int          n;
    int          nops;
    bit          bad;
    if (!(opc == OP_ECHO || opc == OP_ADD || opc == OP_MUL || opc == OP_DIV)) begin
      exp_err.push_back(2'd1);
      send_byte(opc);
    end else begin
      send_byte(opc);
      send_byte(8'($urandom_range(0, 255)));
      send_byte(len[7:0]);
      send_byte(len[15:8]);
      if (len < 4) begin
        exp_err.push_back(2'd2);
      end else if (len > 4) begin
        n = len - 4;
        for (int i = 0; i < n; i++) begin
          if (next_pl.size() > 0) pl.push_back(next_pl.pop_front());
          else                    pl.push_back(8'($urandom_range(0, 255)));
        end
        bad = (opc != OP_ECHO) &&
              (((n % OPB) != 0) || (opc == OP_DIV && n != 2 * OPB) ||
               (opc != OP_DIV && n > MAX_OPS * OPB));
        if (bad) begin
          exp_err.push_back(2'd3);
        end else if (opc == OP_ECHO) begin
          for (int i = 0; i < n; i++) exp_echo.push_back(pl[i]);
        end else begin
          nops = n / OPB;
          for (int k = 0; k < nops; k++) begin
            v = 64'd0;
            for (int j = 0; j < OPB; j++) v = v | (64'(pl[k*OPB+j]) << (8 * j));
            exp_opnd.push_back(v);
            exp_last.push_back(k == nops - 1);
            exp_opc.push_back(opc);
          end
        end
        for (int i = 0; i < n; i++) send_byte(pl[i]);
      end
    end
    next_pl.delete();
    wait_idle();
    compare_and_clear();
  endtask

  function automatic logic [7:0] pick_opc(input int sel);
    case (sel % 4)
      0:       return OP_ECHO;
      1:       return OP_ADD;
      2:       return OP_MUL;
      default: return OP_DIV;
    endcase
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"},       64'(busy_o),       64'd0);
    check_eq({tag, "_opnd_valid"}, 64'(opnd_valid_o), 64'd0);
    check_eq({tag, "_opnd_last"},  64'(opnd_last_o),  64'd0);
    check_eq({tag, "_opnd_data"},  64'(opnd_data_o),  64'd0);
    check_eq({tag, "_echo_valid"}, 64'(echo_valid_o), 64'd0);
    check_eq({tag, "_err"},        64'(err_o),        64'd0);
    check_eq({tag, "_err_code"},   64'(err_code_o),   64'd0);
    check_eq({tag, "_rx_ready"},   64'(rx_ready_o),   64'd0);
  endtask

  initial begin
    int cat;
    int k;
    logic [7:0] opc;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("post_reset_rx_ready", 64'(rx_ready_o), 64'd1);
    check_eq("post_reset_busy", 64'(busy_o), 64'd0);

    // ECHO of three bytes
    next_pl = '{8'h41, 8'h42, 8'h43};
    run_packet(OP_ECHO, 7);

    // Two ADD operands
    next_pl = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    run_packet(OP_ADD, 12);

    // Same packet with the ALU stalled on the first operand
    hold_opnd = 1'b1;
    exp_opnd.push_back(64'h1); exp_last.push_back(1'b0); exp_opc.push_back(OP_ADD);
    exp_opnd.push_back(64'h2); exp_last.push_back(1'b1); exp_opc.push_back(OP_ADD);
    send_byte(OP_ADD); send_byte(8'h00); send_byte(8'h0C); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    rx_data_i  = 8'h02;
    rx_valid_i = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_eq("stall_valid", 64'(opnd_valid_o), 64'd1);
      check_eq("stall_data", 64'(opnd_data_o), 64'h1);
      check_eq("stall_rx_ready", 64'(rx_ready_o), 64'd0);
    end
    @(posedge clk);
    #1;
    hold_opnd = 1'b0;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    wait_idle();
    compare_and_clear();

    // DIV with a 12-byte payload is drained, then an ECHO resyncs
    run_packet(OP_DIV, 16);
    run_packet(OP_ECHO, 9);

    // Bad opcode, then a too-short length
    run_packet(8'h00, 0);
    run_packet(OP_ADD, 2);
    run_packet(OP_MUL, 4);

    // Reset between the second and third operand bytes
    send_byte(OP_ADD); send_byte(8'h00); send_byte(8'h0C); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22);
    #3;
    rst = 1'b1;
    #1;
    check_idle_outputs("midreset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    clear_queues();
    next_pl = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hCD, 8'hAB, 8'h89};
    run_packet(OP_ADD, 12);

    // Randomised packet mix
    for (int it = 0; it < 120; it++) begin
      cat = $urandom_range(0, 5);
      case (cat)
        0: begin
          opc = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom_range(5, 255));
          run_packet(opc, 0);
        end
        1: run_packet(pick_opc($urandom_range(0, 3)), $urandom_range(0, 4));
        2: run_packet(OP_ECHO, $urandom_range(5, 24));
        3: begin
          k = $urandom_range(1, MAX_OPS + 1);
          run_packet(($urandom_range(0, 1) != 0) ? OP_ADD : OP_MUL, 4 + k * OPB);
        end
        4: begin
          k = $urandom_range(1, 3);
          run_packet(OP_DIV, 4 + k * OPB);
        end
        default: run_packet(pick_opc($urandom_range(0, 3)), $urandom_range(5, 40));
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
